gp_ctr_stream: RTL and testbench

GP_CTR_STREAM -- requirements
Module: gp_ctr_stream

---
 rtl/gp_ctr_stream.sv | 185 ++++++++++++++++++
 tb/tb_gp_ctr_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_ctr_stream.sv
// Generic FIFO: power-of-2 depth, head visible at rd_dat_o whenever rd_vld_o is high.
// Latency: a pushed entry can be popped on the cycle after the push.
// Backpressure: none internally; the writer guarantees it never pushes into a full queue.
module gp_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         rd_vld_o,
    output logic [W-1:0] rd_dat_o,
    input  logic         rd_rdy_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_vld_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_vld_o && rd_rdy_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

    assign rd_vld_o = (wr_ptr_q != rd_ptr_q);
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// CTR-mode stream wrapper: issues counter blocks to a cipher core and XORs keystream onto plaintext.
// Latency: acceptance to valid_o is core latency + 2 cycles; one block per cycle sustained.
// Backpressure: busy_o when not running, DEPTH blocks in flight, or a start is taken; output holds until ack_i.
module gp_ctr_stream #(
    parameter int DEPTH = 16,
    parameter int CTR_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] iv_i,
    input  logic [127:0] data_i,
    input  logic         request_i,
    output logic         busy_o,
    output logic [127:0] data_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [127:0] core_data_o,
    output logic         core_request_o,
    input  logic [127:0] core_data_i,
    input  logic         core_valid_i,
    output logic         wrap_o
);
    localparam int IW = $clog2(DEPTH) + 1;
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state_q, state_d;
    logic [127:0]       iv_hi_q, iv_hi_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [IW-1:0]      inflight_q, inflight_d;
    logic [IW-1:0]      pend_q, pend_d;
    logic               wrap_q, wrap_d;
    logic               valid_q, valid_d;
    logic               creq_q, creq_d;
    logic [127:0]       data_q, data_d;
    logic [127:0]       cdat_q, cdat_d;

    logic               start_acc, accept, deliver, ks_push, pop;
    logic               pt_vld, ks_vld;
    logic [127:0]       pt_dat, ks_dat;

    // A start is only honoured once every accepted block has been delivered.
    assign start_acc = start_i && (inflight_q == '0);
    assign busy_o    = (state_q != RUN) || (inflight_q == IW'(DEPTH)) || start_acc;
    assign accept    = request_i && !busy_o;
    assign deliver   = valid_q && ack_i;
    // Keystream with no request outstanding (e.g. after a reset) is discarded.
    assign ks_push   = core_valid_i && (pend_q != '0);
    assign pop       = pt_vld && ks_vld && (!valid_q || ack_i);

    gp_fifo #(.W(128), .DEPTH(DEPTH)) u_pt_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (accept),
        .wr_dat_i (data_i),
        .rd_vld_o (pt_vld),
        .rd_dat_o (pt_dat),
        .rd_rdy_i (pop)
    );

    gp_fifo #(.W(128), .DEPTH(DEPTH)) u_ks_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (ks_push),
        .wr_dat_i (core_data_i),
        .rd_vld_o (ks_vld),
        .rd_dat_o (ks_dat),
        .rd_rdy_i (pop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_acc) begin
            state_d = RUN;
        end else if (accept && (ctr_q == '1)) begin
            state_d = HALT;
        end
    end

    always_comb begin
        iv_hi_d    = iv_hi_q;
        ctr_d      = ctr_q;
        wrap_d     = wrap_q;
        creq_d     = accept;
        cdat_d     = cdat_q;
        inflight_d = inflight_q + IW'(accept) - IW'(deliver);
        pend_d     = pend_q + IW'(creq_q) - IW'(ks_push);
        valid_d    = valid_q;
        data_d     = data_q;

        if (start_acc) begin
            iv_hi_d = iv_i & ~CTR_MASK;
            ctr_d   = iv_i[CTR_W-1:0];
            wrap_d  = 1'b0;
        end
        if (accept) begin
            cdat_d = iv_hi_q | 128'(ctr_q);
            ctr_d  = ctr_q + CTR_W'(1);
            if (ctr_q == '1) wrap_d = 1'b1;
        end
        if (pop) begin
            valid_d = 1'b1;
            data_d  = pt_dat ^ ks_dat;
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iv_hi_q    <= '0;
            ctr_q      <= '0;
            wrap_q     <= 1'b0;
            creq_q     <= 1'b0;
            cdat_q     <= '0;
            inflight_q <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            iv_hi_q    <= iv_hi_d;
            ctr_q      <= ctr_d;
            wrap_q     <= wrap_d;
            creq_q     <= creq_d;
            cdat_q     <= cdat_d;
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign core_data_o    = cdat_q;
    assign core_request_o = creq_q;
    assign wrap_o         = wrap_q;
endmodule

// File: tb/tb_gp_ctr_stream.sv
// Bench for gp_ctr_stream: two instances (16-deep/64-bit and 4-deep/8-bit counter), one observed at a time.
// A queue-based scoreboard predicts acceptance, ordering and ciphertext; a delayed-echo core model closes the loop.
module tb_gp_ctr_stream;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, request_i, ack_i, core_valid_i;
    logic [127:0] iv_i, data_i, core_data_i;

    logic         busy_a, valid_a, creq_a, wrap_a;
    logic [127:0] data_a, cdat_a;
    logic         busy_b, valid_b, creq_b, wrap_b;
    logic [127:0] data_b, cdat_b;

    logic         sel;
    logic         s_busy, s_valid, s_creq, s_wrap;
    logic [127:0] s_data, s_cdat;

    always #5 clk = ~clk;

    gp_ctr_stream #(.DEPTH(16), .CTR_W(64)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_i), .iv_i(iv_i), .data_i(data_i),
        .request_i(request_i), .busy_o(busy_a), .data_o(data_a), .valid_o(valid_a),
        .ack_i(ack_i), .core_data_o(cdat_a), .core_request_o(creq_a),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .wrap_o(wrap_a)
    );

    gp_ctr_stream #(.DEPTH(4), .CTR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_i), .iv_i(iv_i), .data_i(data_i),
        .request_i(request_i), .busy_o(busy_b), .data_o(data_b), .valid_o(valid_b),
        .ack_i(ack_i), .core_data_o(cdat_b), .core_request_o(creq_b),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .wrap_o(wrap_b)
    );

    assign s_busy  = sel ? busy_b  : busy_a;
    assign s_valid = sel ? valid_b : valid_a;
    assign s_creq  = sel ? creq_b  : creq_a;
    assign s_wrap  = sel ? wrap_b  : wrap_a;
    assign s_data  = sel ? data_b  : data_a;
    assign s_cdat  = sel ? cdat_b  : cdat_a;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_acc = 0, n_del = 0, n_vseen = 0;
    int first_acc_cyc, first_val_cyc;
    int m_inflight, m_depth, lat, last_due;
    bit lat_rand, m_run, m_wrap, hold_pending;
    logic [127:0] m_iv, m_ctr, m_mask, hold_dat;
    logic [127:0] exp_q[$];
    int           due_q[$];
    logic [127:0] cd_q[$];

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cipher core: echoes each counter block back in issue order after its latency.
    task automatic core_model();
        int d;
        core_valid_i = 1'b0;
        core_data_i  = rnd128();
        if (s_creq) begin
            d = cyc + (lat_rand ? int'($urandom_range(1, 8)) : lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            due_q.push_back(d);
            cd_q.push_back(s_cdat);
        end
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            core_data_i  = cd_q.pop_front();
            core_valid_i = 1'b1;
        end
    endtask

    // One clock: check outputs against the model, update the model for this edge, then run the core.
    task automatic tick();
        bit start_ok, m_busy, acc, del;
        #1;
        if (!rst) begin
            chk("rst_busy", s_busy, 1'b1);
            chk("rst_valid", s_valid, 1'b0);
            chk("rst_core_req", s_creq, 1'b0);
            chk("rst_wrap", s_wrap, 1'b0);
            chk("rst_data", s_data, '0);
            chk("rst_core_data", s_cdat, '0);
            m_run = 0; m_wrap = 0; m_inflight = 0; m_iv = '0; m_ctr = '0;
            hold_pending = 0;
            exp_q.delete();
        end else begin
            start_ok = start_i && (m_inflight == 0);
            m_busy   = !m_run || (m_inflight == m_depth) || start_ok;
            chk("busy", s_busy, m_busy);
            chk("wrap", s_wrap, m_wrap);
            if (hold_pending) begin
                chk("hold_valid", s_valid, 1'b1);
                chk("hold_data", s_data, hold_dat);
            end
            if (s_valid) begin
                n_vseen++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
            end
            acc = request_i && !m_busy;
            del = s_valid && ack_i;
            if (del) begin
                chk("deliver_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk("data", s_data, exp_q.pop_front());
                    n_del++;
                end
                if (m_inflight > 0) m_inflight--;
            end
            if (acc) begin
                exp_q.push_back(data_i ^ ((m_iv & ~m_mask) | m_ctr));
                m_inflight++;
                n_acc++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
                if (m_ctr == m_mask) begin
                    m_run  = 0;
                    m_wrap = 1;
                end
                m_ctr = (m_ctr + 128'd1) & m_mask;
            end
            if (start_ok) begin
                m_run  = 1;
                m_wrap = 0;
                m_iv   = iv_i;
                m_ctr  = iv_i & m_mask;
            end
            hold_pending = s_valid && !ack_i;
            hold_dat     = s_data;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        core_model();
    endtask

    task automatic do_reset();
        start_i = 0; request_i = 0;
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic start_run(input logic [127:0] iv);
        iv_i = iv; start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic drain(input int budget);
        request_i = 0; start_i = 0; ack_i = 1;
        for (int i = 0; i < budget && m_inflight != 0; i++) tick();
        chk("drain_done", m_inflight, 0);
    endtask

    initial begin
        int abase, dbase, vbase;
        logic [127:0] iv;
        rst = 1; start_i = 0; request_i = 0; ack_i = 0; core_valid_i = 0;
        iv_i = '0; data_i = '0; core_data_i = '0;
        sel = 0; m_depth = 16; m_mask = {64'h0, {64{1'b1}}};
        lat = 3; lat_rand = 0; last_due = 0; hold_pending = 0;
        m_run = 0; m_wrap = 0; m_inflight = 0; m_iv = '0; m_ctr = '0;
        @(negedge clk);
        do_reset();
        tick();

        // Streaming: 11 zero blocks through a 3-cycle identity core.
        first_acc_cyc = -1; first_val_cyc = -1;
        abase = n_acc; dbase = n_del;
        start_run(128'h1234567890abcef0_0000000000000000);
        ack_i = 1; request_i = 1; data_i = '0;
        for (int i = 0; i < 11; i++) tick();
        chk("stream_accepts", n_acc - abase, 11);
        drain(60);
        chk("stream_delivered", n_del - dbase, 11);
        chk("stream_latency", first_val_cyc - first_acc_cyc, 5);

        // Start while blocks are in flight is ignored; counter and iv carry on.
        do_reset();
        iv = rnd128(); iv[63:0] = {32'h0, $urandom()};
        start_run(iv);
        dbase = n_del;
        request_i = 1;
        for (int i = 0; i < 2; i++) begin data_i = rnd128(); tick(); end
        request_i = 0;
        iv_i = rnd128(); start_i = 1;
        tick();
        start_i = 0; request_i = 1;
        for (int i = 0; i < 2; i++) begin data_i = rnd128(); tick(); end
        drain(60);
        chk("start_busy_delivered", n_del - dbase, 4);

        // Start together with request from IDLE: the request must not be taken.
        do_reset();
        vbase = n_vseen;
        iv_i = rnd128(); start_i = 1; request_i = 1; data_i = rnd128();
        tick();
        start_i = 0; request_i = 0; ack_i = 1;
        for (int i = 0; i < 12; i++) tick();
        chk("start_req_no_output", n_vseen - vbase, 0);

        // Reset with 5 blocks in flight; late keystream must not produce output.
        do_reset();
        lat = 6;
        iv = rnd128(); iv[63:0] = 64'h100;
        start_run(iv);
        request_i = 1; ack_i = 1;
        for (int i = 0; i < 5; i++) begin data_i = rnd128(); tick(); end
        request_i = 0;
        rst = 0;
        tick();
        rst = 1;
        vbase = n_vseen;
        for (int i = 0; i < 14; i++) tick();
        chk("late_ks_no_valid", n_vseen - vbase, 0);
        chk("late_ks_consumed", due_q.size(), 0);
        lat = 3; dbase = n_del;
        start_run(rnd128());
        request_i = 1;
        for (int i = 0; i < 3; i++) begin data_i = rnd128(); tick(); end
        drain(60);
        chk("post_reset_delivered", n_del - dbase, 3);

        // Random traffic: 1000 blocks, random core latency, request and ack.
        do_reset();
        lat_rand = 1;
        iv = rnd128(); iv[63:0] = {32'h0, $urandom()};
        start_run(iv);
        abase = n_acc; dbase = n_del;
        for (int i = 0; i < 20000 && (n_acc - abase) < 1000; i++) begin
            request_i = ($urandom_range(0, 3) != 0);
            ack_i     = ($urandom_range(0, 3) != 0);
            data_i    = rnd128();
            tick();
        end
        chk("rand_accepted", n_acc - abase, 1000);
        drain(400);
        chk("rand_delivered", n_del - dbase, 1000);
        chk("rand_scoreboard_empty", exp_q.size(), 0);
        lat_rand = 0;

        // Backpressure on the 4-deep instance.
        sel = 1; m_depth = 4; m_mask = 128'hFF;
        do_reset();
        iv = rnd128(); iv[7:0] = 8'h10;
        start_run(iv);
        abase = n_acc; dbase = n_del;
        ack_i = 0; request_i = 1;
        for (int i = 0; i < 20; i++) begin data_i = rnd128(); tick(); end
        chk("bp_accepts", n_acc - abase, 4);
        chk("bp_busy", s_busy, 1'b1);
        chk("bp_valid", s_valid, 1'b1);
        chk("bp_head", s_data, exp_q[0]);
        ack_i = 1;
        for (int i = 0; i < 6; i++) begin data_i = rnd128(); tick(); end
        drain(60);
        chk("bp_delivered", n_del - dbase, n_acc - abase);

        // Counter wrap on the 8-bit instance.
        do_reset();
        iv = rnd128(); iv[7:0] = 8'hFE;
        start_run(iv);
        abase = n_acc; dbase = n_del;
        ack_i = 1; request_i = 1;
        for (int i = 0; i < 3; i++) begin data_i = rnd128(); tick(); end
        request_i = 0;
        chk("wrap_accepts", n_acc - abase, 2);
        chk("wrap_set", s_wrap, 1'b1);
        chk("wrap_busy", s_busy, 1'b1);
        drain(60);
        chk("wrap_delivered", n_del - dbase, 2);
        start_run(iv);
        tick();
        chk("wrap_cleared", s_wrap, 1'b0);
        chk("wrap_restart_busy", s_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
